mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address for lw/lbu/lhu/sw/sb/sh, checks alignment, and runs one transaction on the data bus using a req/ack handshake. It steers byte lanes for stores, extracts and zero-extends load data, and stalls the pipeline while the bus inserts wait states.

Parameters:
ADDR_W, 32, effective address width (ALU result width)
DATA_W, 32, bus data width; fixed at 32 in this revision
TIMEOUT_CYCLES, 16, REQ-state cycles before abort; used only when BUS_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  operation valid from execute; sampled only when ready=1
op  in  3  000 LW, 001 LBU, 010 LHU, 011 SW, 100 SB, 101 SH; 110/111 illegal
addr  in  32  effective address (ALU r output)
wdata  in  32  store data (rt value)
ready  out  1  unit idle and able to accept start
busy  out  1  pipeline stall request
done  out  1  one-cycle completion pulse
rdata  out  32  load result, zero-extended; valid when done=1
misalign  out  1  with done: alignment fault or illegal op, no bus access made
timeout  out  1  with done: bus abort (BUS_TIMEOUT_EN only, else tied 0)
bus_req  out  1  transaction request
bus_we  out  1  1=write
bus_addr  out  32  word address, bits[1:0] forced to 00
bus_be  out  4  byte enables; be[3] = byte offset 0 (big-endian)
bus_wdata  out  32  lane-steered store data
bus_ack  in  1  transaction complete this cycle
bus_rdata  in  32  read data, valid when bus_ack=1

Behaviour:
- Reset (async, immediate): state IDLE; ready=1; busy, done, misalign, timeout, bus_req and bus_we are 0; bus_addr, bus_be, bus_wdata and rdata are 0. A transaction in flight is dropped, with bus_req falling at reset assertion.
- FSM states: IDLE, REQ, RESP.
- IDLE with start=1:
  - Latch op, addr and wdata.
  - Alignment rule: LW/SW need addr[1:0]=00; LHU/SH need addr[0]=0; bytes are always aligned.
  - Legal and aligned: go to REQ.
  - Misaligned or illegal op: go to RESP with misalign=1 and no bus activity.
- REQ:
  - bus_req=1 and busy=1; bus outputs held stable.
  - Completion is the first rising edge with bus_req & bus_ack; capture bus_rdata, then go to RESP.
  - bus_ack while not in REQ is ignored.
- RESP:
  - done=1 for exactly one cycle; busy=0; rdata valid.
  - Return to IDLE; start is ignored in RESP.
- Minimum latency: start at cycle N, bus_req at N+1, ack at N+1, done at N+2. Each wait cycle adds 1.
- ready is 1 only in IDLE. busy is 1 in REQ, and also in the start cycle, combinationally, when a legal op is accepted.
- Store steering (byte offset o = addr[1:0]):
  - SB: byte replicated on all lanes; be = 4'b1000 >> o.
  - SH: halfword replicated; be = 1100 (o=0) or 0011 (o=2).
  - SW: be = 1111, data unchanged.
- Load extraction:
  - LBU: byte o, where o=0 selects bits[31:24], zero-extended.
  - LHU: o=0 selects [31:16], o=2 selects [15:0], zero-extended.
  - LW: full word.
  - Loads drive be to the accessed lanes, same pattern as the matching store.
- rdata holds until the next done; it is 0 after a store, a misalign or a timeout.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop bus_req and go to RESP with timeout=1 and rdata=0.
  - An ack arriving in the same cycle as the limit wins: normal completion.
- Undefined: REQ waits indefinitely, timeout is tied 0, and no counter logic exists.

Decomposition:
- Package plp_mem_pkg holds:
  - the op encoding localparams (OP_LW … OP_SH);
  - the FSM state encoding;
  - the byte-enable constants BE_WORD, BE_HI_HALF, BE_LO_HALF, BE_BYTE0.
- One combinational sub-module, mem_lane_align: inputs op, offset, wdata and bus_rdata; outputs be, steered wdata and extracted rdata. It is shared by the FSM wrapper and reusable by an instruction-fetch path.

Test Plan:
- LW addr=0x0000_1004, ack on first req cycle -> bus_addr=0x1004, be=1111, rdata=bus_rdata=0xDEADBEEF, done at N+2.
- SB addr=0x2003, wdata=0x0000_00A5, 3 wait cycles -> be=0001, bus_wdata=0xA5A5A5A5, bus_we=1, busy high 4 cycles, done at N+5.
- LHU addr=0x3002, bus_rdata=0x1234_8765 -> rdata=0x0000_8765. LBU addr=0x3000 -> rdata=0x0000_0012.
- SW addr=0x4002 (misaligned), and op=110 -> no bus_req, done+misalign at N+1, rdata=0.
- rst asserted mid-REQ on a 10-wait-cycle read -> bus_req drops immediately, ready=1, no done pulse. Next LW completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> done+timeout after 16 REQ cycles, bus_req low. Ack in cycle 16 -> normal done with timeout=0.

Source files
------------

// File: rtl/plp_mem_pkg.sv
// Shared encodings for the memory-access stage: op codes, FSM states, byte enables
// and the legality/alignment helpers used when an operation is accepted.
package plp_mem_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_SB  = 3'b100;
  localparam logic [2:0] OP_SH  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Big-endian lanes: be[3] is byte offset 0.
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SH;
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] off);
    logic ok;
    case (op)
      OP_LW, OP_SW:   ok = (off == 2'b00);
      OP_LHU, OP_SH:  ok = ~off[0];
      default:        ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for stores and zero-extending extraction for loads.
// Shared by the data-memory stage and any fetch path needing the same lane rules.
module mem_lane_align
  import plp_mem_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;

    case (op_i)
      OP_LW, OP_SW:   be_o = BE_WORD;
      OP_LBU, OP_SB:  be_o = BE_BYTE0 >> offset_i;
      OP_LHU, OP_SH:  be_o = offset_i[1] ? BE_LO_HALF : BE_HI_HALF;
      default:        be_o = '0;
    endcase

    // Sub-word stores replicate the datum so every enabled lane sees it.
    case (op_i)
      OP_SW:   wdata_o = wdata_i;
      OP_SB:   wdata_o = {4{wdata_i[7:0]}};
      OP_SH:   wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = '0;
    endcase

    case (op_i)
      OP_LW:  rdata_o = bus_rdata_i;
      OP_LBU: begin
        case (offset_i)
          2'd0:    rdata_o = {24'h0, bus_rdata_i[31:24]};
          2'd1:    rdata_o = {24'h0, bus_rdata_i[23:16]};
          2'd2:    rdata_o = {24'h0, bus_rdata_i[15:8]};
          default: rdata_o = {24'h0, bus_rdata_i[7:0]};
        endcase
      end
      OP_LHU: rdata_o = offset_i[1] ? {16'h0, bus_rdata_i[15:0]} : {16'h0, bus_rdata_i[31:16]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: alignment check, one req/ack bus transaction, pipeline stall.
// Optional macro BUS_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES unacknowledged cycles.
module mem_access_unit
  import plp_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misalign_o,
  output logic              timeout_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  state_e            state_q;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic              bus_req_q, bus_we_q, done_q, misalign_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [DATA_W-1:0] bus_wdata_q, rdata_q;

  logic              accept_d;
  logic [2:0]        lane_op;
  logic [1:0]        lane_off;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, lane_rdata;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_q;
`endif

  assign accept_d = start_i && op_legal(op_i) && op_aligned(op_i, addr_i[1:0]);

  // In IDLE the lane logic looks at the incoming op so the bus fields are ready to register.
  assign lane_op  = (state_q == ST_IDLE) ? op_i : op_q;
  assign lane_off = (state_q == ST_IDLE) ? addr_i[1:0] : off_q;

  mem_lane_align u_lane (
    .op_i        (lane_op),
    .offset_i    (lane_off),
    .wdata_i     (wdata_i),
    .bus_rdata_i (bus_rdata_i),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      off_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_q  <= op_i;
            off_q <= addr_i[1:0];
            if (accept_d) begin
              state_q     <= ST_REQ;
              bus_req_q   <= 1'b1;
              bus_we_q    <= op_is_store(op_i);
              bus_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
              bus_be_q    <= lane_be;
              bus_wdata_q <= lane_wdata;
`ifdef BUS_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end else begin
              state_q    <= ST_RESP;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
              rdata_q    <= '0;
            end
          end
        end
        ST_REQ: begin
          if (bus_ack_i) begin
            state_q   <= ST_RESP;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            done_q    <= 1'b1;
            rdata_q   <= lane_rdata;
`ifdef BUS_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= ST_RESP;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            rdata_q   <= '0;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          state_q    <= ST_IDLE;
          done_q     <= 1'b0;
          misalign_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
          timeout_q  <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_REQ) || ((state_q == ST_IDLE) && accept_d);
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign misalign_o  = misalign_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
`ifdef BUS_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, lane steering, misalignment,
// mid-transaction reset and (with BUS_TIMEOUT_EN) bus timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        ready, busy, done, misalign, timeout;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;

  // Observations captured by runOp for the scenario tasks to compare.
  int          rLat, rBusyCnt;
  logic        rBusy0, rReqSeen, rWe, rDone, rMis, rTo, rReadyAfter;
  logic [31:0] rAddr, rWdata, rRdata;
  logic [3:0]  rBe;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .op_i        (op),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .ready_o     (ready),
    .busy_o      (busy),
    .done_o      (done),
    .rdata_o     (rdata),
    .misalign_o  (misalign),
    .timeout_o   (timeout),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_be_o    (bus_be),
    .bus_wdata_o (bus_wdata),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and plays the bus slave: acks after 'waits' unacknowledged REQ cycles.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int waits);
    int wc;
    wc = 0;
    start = 1'b1; op = o; addr = a; wdata = d;
    #1;
    rBusy0 = busy;
    step();
    start = 1'b0;
    rLat = 1; rBusyCnt = 0;
    rReqSeen = bus_req;
    rAddr = bus_addr; rBe = bus_be; rWdata = bus_wdata; rWe = bus_we;
    while (!done && rLat < 60) begin
      rReqSeen = rReqSeen | bus_req;
      if (busy) rBusyCnt++;
      bus_ack   = bus_req && (wc == waits);
      bus_rdata = bus_ack ? rd : 32'h0;
      if (bus_req) wc++;
      step();
      rLat++;
    end
    bus_ack = 1'b0; bus_rdata = 32'h0;
    rDone = done; rMis = misalign; rTo = timeout; rRdata = rdata;
    step();
    rReadyAfter = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'b0; addr = 32'h0; wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    total++; if ({ready, busy, done, misalign, timeout, bus_req, bus_we} !== 7'b1000000) begin
      bad++; $display("FAIL reset_flags: got %b want 1000000", {ready, busy, done, misalign, timeout, bus_req, bus_we});
    end
    total++; if ({bus_addr, bus_be, bus_wdata, rdata} !== 100'h0) begin
      bad++; $display("FAIL reset_data: got addr=%h be=%b wd=%h rd=%h want all 0", bus_addr, bus_be, bus_wdata, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_word();
    runOp(3'b000, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    total++; if (rLat !== 2) begin bad++; $display("FAIL lw_latency: got %0d want 2", rLat); end
    total++; if (rBusy0 !== 1'b1) begin bad++; $display("FAIL lw_busy_start: got %b want 1", rBusy0); end
    total++; if (rAddr !== 32'h1004 || rBe !== 4'b1111 || rWe !== 1'b0) begin
      bad++; $display("FAIL lw_bus: got addr=%h be=%b we=%b want 1004 1111 0", rAddr, rBe, rWe);
    end
    total++; if (rRdata !== 32'hDEAD_BEEF || rDone !== 1'b1) begin
      bad++; $display("FAIL lw_rdata: got %h done=%b want deadbeef 1", rRdata, rDone);
    end
    total++; if (rMis !== 1'b0 || rTo !== 1'b0) begin
      bad++; $display("FAIL lw_flags: got mis=%b to=%b want 0 0", rMis, rTo);
    end
    total++; if (rdata !== 32'hDEAD_BEEF || done !== 1'b0 || rReadyAfter !== 1'b1) begin
      bad++; $display("FAIL lw_hold: got rd=%h done=%b ready=%b want deadbeef 0 1", rdata, done, rReadyAfter);
    end
  endtask

  task automatic test_store_byte_wait();
    runOp(3'b100, 32'h0000_2003, 32'h0000_00A5, 32'h0, 3);
    total++; if (rLat !== 5) begin bad++; $display("FAIL sb_latency: got %0d want 5", rLat); end
    total++; if (rBusyCnt !== 4) begin bad++; $display("FAIL sb_busy_cycles: got %0d want 4", rBusyCnt); end
    total++; if (rAddr !== 32'h2000 || rBe !== 4'b0001 || rWdata !== 32'hA5A5_A5A5 || rWe !== 1'b1) begin
      bad++; $display("FAIL sb_bus: got addr=%h be=%b wd=%h we=%b want 2000 0001 a5a5a5a5 1", rAddr, rBe, rWdata, rWe);
    end
    total++; if (rRdata !== 32'h0) begin bad++; $display("FAIL sb_rdata: got %h want 0", rRdata); end
  endtask

  task automatic test_load_extract();
    runOp(3'b010, 32'h0000_3002, 32'h0, 32'h1234_8765, 1);
    total++; if (rRdata !== 32'h0000_8765 || rBe !== 4'b0011 || rAddr !== 32'h3000) begin
      bad++; $display("FAIL lhu_lo: got rd=%h be=%b addr=%h want 00008765 0011 3000", rRdata, rBe, rAddr);
    end
    runOp(3'b010, 32'h0000_3000, 32'h0, 32'h1234_8765, 0);
    total++; if (rRdata !== 32'h0000_1234 || rBe !== 4'b1100) begin
      bad++; $display("FAIL lhu_hi: got rd=%h be=%b want 00001234 1100", rRdata, rBe);
    end
    runOp(3'b001, 32'h0000_3000, 32'h0, 32'h1234_8765, 0);
    total++; if (rRdata !== 32'h0000_0012 || rBe !== 4'b1000) begin
      bad++; $display("FAIL lbu_b0: got rd=%h be=%b want 00000012 1000", rRdata, rBe);
    end
    runOp(3'b001, 32'h0000_3003, 32'h0, 32'h1234_8765, 0);
    total++; if (rRdata !== 32'h0000_0065 || rBe !== 4'b0001) begin
      bad++; $display("FAIL lbu_b3: got rd=%h be=%b want 00000065 0001", rRdata, rBe);
    end
  endtask

  task automatic test_store_steer();
    runOp(3'b101, 32'h0000_5002, 32'hABCD_1234, 32'h0, 0);
    total++; if (rBe !== 4'b0011 || rWdata !== 32'h1234_1234 || rWe !== 1'b1) begin
      bad++; $display("FAIL sh_bus: got be=%b wd=%h we=%b want 0011 12341234 1", rBe, rWdata, rWe);
    end
    runOp(3'b011, 32'h0000_6000, 32'hCAFE_F00D, 32'h0, 2);
    total++; if (rBe !== 4'b1111 || rWdata !== 32'hCAFE_F00D || rAddr !== 32'h6000 || rLat !== 4) begin
      bad++; $display("FAIL sw_bus: got be=%b wd=%h addr=%h lat=%0d want 1111 cafef00d 6000 4", rBe, rWdata, rAddr, rLat);
    end
  endtask

  task automatic test_misalign();
    runOp(3'b000, 32'h0000_1000, 32'h0, 32'h1111_2222, 0);
    total++; if (rRdata !== 32'h1111_2222) begin bad++; $display("FAIL mis_pre_lw: got %h want 11112222", rRdata); end
    runOp(3'b011, 32'h0000_4002, 32'h5555_5555, 32'h0, 0);
    total++; if (rLat !== 1 || rReqSeen !== 1'b0 || rMis !== 1'b1 || rRdata !== 32'h0 || rBusy0 !== 1'b0) begin
      bad++; $display("FAIL mis_sw: got lat=%0d req=%b mis=%b rd=%h busy=%b want 1 0 1 0 0", rLat, rReqSeen, rMis, rRdata, rBusy0);
    end
    runOp(3'b110, 32'h0000_4000, 32'h0, 32'h0, 0);
    total++; if (rLat !== 1 || rReqSeen !== 1'b0 || rMis !== 1'b1 || rDone !== 1'b1) begin
      bad++; $display("FAIL mis_illegal: got lat=%0d req=%b mis=%b done=%b want 1 0 1 1", rLat, rReqSeen, rMis, rDone);
    end
    runOp(3'b010, 32'h0000_3001, 32'h0, 32'h0, 0);
    total++; if (rMis !== 1'b1 || rReqSeen !== 1'b0) begin
      bad++; $display("FAIL mis_lhu: got mis=%b req=%b want 1 0", rMis, rReqSeen);
    end
  endtask

  task automatic test_reset_mid_req();
    int dn;
    start = 1'b1; op = 3'b000; addr = 32'h0000_7000;
    step();
    start = 1'b0;
    repeat (4) step();
    total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_before: got %b want 1", bus_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus_req !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_drop: got req=%b ready=%b busy=%b want 0 1 0", bus_req, ready, busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      step();
      if (done) dn++;
    end
    total++; if (dn !== 0 || ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_nodone: got done_pulses=%0d ready=%b want 0 1", dn, ready);
    end
    runOp(3'b000, 32'h0000_7004, 32'h0, 32'h0BAD_F00D, 0);
    total++; if (rLat !== 2 || rRdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL rstmid_next_lw: got lat=%0d rd=%h want 2 0badf00d", rLat, rRdata);
    end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    runOp(3'b000, 32'h0000_8000, 32'h0, 32'h7777_7777, 1000);
    total++; if (rLat !== 17 || rTo !== 1'b1 || rDone !== 1'b1 || rRdata !== 32'h0) begin
      bad++; $display("FAIL to_abort: got lat=%0d to=%b done=%b rd=%h want 17 1 1 0", rLat, rTo, rDone, rRdata);
    end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL to_req_low: got %b want 0", bus_req); end
    runOp(3'b000, 32'h0000_8004, 32'h0, 32'h7777_7777, 15);
    total++; if (rLat !== 17 || rTo !== 1'b0 || rRdata !== 32'h7777_7777) begin
      bad++; $display("FAIL to_ack_wins: got lat=%0d to=%b rd=%h want 17 0 77777777", rLat, rTo, rRdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_store_byte_wait();
    test_load_extract();
    test_store_steer();
    test_misalign();
    test_reset_mid_req();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
